// File: rtl/usr_pkg.sv
// Package for the universal shift register.
// Holds the 3-bit operation encodings shared by the RTL and its testbench,
// plus a helper that identifies modes which advance the shift counter.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // SHL, SHR, ROL, ROR and ASR each count as one shift operation.
  function automatic logic is_shift(input logic [2:0] mode);
    return (mode != MODE_HOLD) && (mode != MODE_LOAD) && (mode != MODE_CLR);
  endfunction

endpackage

// File: rtl/dff_bit.sv
// Single-bit D flip-flop cell with clock enable and a per-instance reset value.
// Ports:
//   Clk    - clock, rising edge active
//   Rst_n  - synchronous active-low reset, loads RstVal
//   En     - clock enable; 0 holds the stored bit
//   RstVal - value taken on reset
//   D      - next-state data
//   Q, Qb  - stored bit and its complement
module dff_bit (
  input  logic Clk,
  input  logic Rst_n,
  input  logic En,
  input  logic RstVal,
  input  logic D,
  output logic Q,
  output logic Qb
);

  logic r_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_q <= RstVal;
    end else if (En) begin
      r_q <= D;
    end
  end

  assign Q  = r_q;
  assign Qb = ~r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: parallel load, shift/rotate/arithmetic shift,
// serial in/out, clock enable, and a saturating shift counter with a Done flag
// so the block can serialise or deserialise a word.
// Ports:
//   Clk, Rst_n     - clock (rising edge) and synchronous active-low reset
//   En             - clock enable for every register including Cnt/Done
//   Mode           - operation select (usr_pkg MODE_* encodings)
//   D              - parallel load data
//   SiL, SiR       - serial inputs for SHL (into bit 0) and SHR (into MSB)
//   Q, Qb          - register contents and complement
//   SoL, SoR       - serial outputs Q[WIDTH-1] and Q[0]
//   Cnt            - shifts since last LOAD/CLR/reset, saturating at WIDTH
//   Done           - registered flag, high when Cnt == WIDTH
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SiL,
  input  logic             SiR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             SoL,
  output logic             SoR,
  output logic [CNT_W-1:0] Cnt,
  output logic             Done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_done;

  // Per-bit next-state mux. Each bit only needs its two neighbours, with the
  // edge bits substituting the serial inputs or the wrapped/sign bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_shl_in;
    logic w_rol_in;
    logic w_shr_in;
    logic w_ror_in;
    logic w_asr_in;
    logic w_d;

    if (i == 0) begin : g_lsb
      assign w_shl_in = SiL;
      assign w_rol_in = w_q[WIDTH-1];
    end else begin : g_lo
      assign w_shl_in = w_q[i-1];
      assign w_rol_in = w_q[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign w_shr_in = SiR;
      assign w_ror_in = w_q[0];
      assign w_asr_in = w_q[WIDTH-1];
    end else begin : g_hi
      assign w_shr_in = w_q[i+1];
      assign w_ror_in = w_q[i+1];
      assign w_asr_in = w_q[i+1];
    end

    always_comb begin
      w_d = w_q[i];
      case (Mode)
        MODE_HOLD: w_d = w_q[i];
        MODE_LOAD: w_d = D[i];
        MODE_SHL:  w_d = w_shl_in;
        MODE_SHR:  w_d = w_shr_in;
        MODE_ROL:  w_d = w_rol_in;
        MODE_ROR:  w_d = w_ror_in;
        MODE_ASR:  w_d = w_asr_in;
        MODE_CLR:  w_d = 1'b0;
        default:   w_d = w_q[i];
      endcase
    end

    dff_bit u_bit (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .En     (En),
      .RstVal (RESET_VAL[i]),
      .D      (w_d),
      .Q      (w_q[i]),
      .Qb     (w_qb[i])
    );
  end

  // Counter saturates at WIDTH so Done stays high across extra shifts.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (Mode == MODE_LOAD || Mode == MODE_CLR) begin
      w_cnt_nxt = '0;
    end else if (is_shift(Mode) && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Done is registered from the next count so it lands on the same edge as Q.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (En) begin
      r_cnt  <= w_cnt_nxt;
      r_done <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign Q    = w_q;
  assign Qb   = w_qb;
  assign SoL  = w_q[WIDTH-1];
  assign SoR  = w_q[0];
  assign Cnt  = r_cnt;
  assign Done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  mode;
  logic        sil;
  logic        sir;
  logic [0:0]  d1;
  logic [7:0]  d8;
  logic [12:0] d13;

  logic [0:0]  q1, qb1;
  logic [7:0]  q8, qb8;
  logic [12:0] q13, qb13;
  logic        sol1, sor1, sol8, sor8, sol13, sor13;
  logic [0:0]  cnt1;
  logic [3:0]  cnt8, cnt13;
  logic        done1, done8, done13;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_w1 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .D(d1), .SiL(sil), .SiR(sir),
    .Q(q1), .Qb(qb1), .SoL(sol1), .SoR(sor1), .Cnt(cnt1), .Done(done1)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u_w8 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .D(d8), .SiL(sil), .SiR(sir),
    .Q(q8), .Qb(qb8), .SoL(sol8), .SoR(sor8), .Cnt(cnt8), .Done(done8)
  );

  univ_shift_reg #(.WIDTH(13), .RESET_VAL(13'h1ABC)) u_w13 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .D(d13), .SiL(sil), .SiR(sir),
    .Q(q13), .Qb(qb13), .SoL(sol13), .SoR(sor13), .Cnt(cnt13), .Done(done13)
  );

  // Reference model: register value as a plain integer, one entry per width.
  int          ws [3] = '{1, 8, 13};
  logic [31:0] rv [3] = '{32'h1, 32'hA5, 32'h1ABC};
  logic [31:0] mq [3];
  int          mcnt [3];
  logic        mdone [3];

  function automatic logic [31:0] model_next(input int w, input logic [31:0] q,
                                             input logic [2:0] m, input logic [31:0] d,
                                             input logic si_l, input logic si_r);
    logic [31:0] mask;
    logic [31:0] msb;
    mask = (32'd1 << w) - 32'd1;
    msb  = (q >> (w - 1)) & 32'd1;
    case (m)
      MODE_LOAD: return d & mask;
      MODE_SHL:  return ((q << 1) | {31'd0, si_l}) & mask;
      MODE_SHR:  return (q >> 1) | ({31'd0, si_r} << (w - 1));
      MODE_ROL:  return ((q << 1) | msb) & mask;
      MODE_ROR:  return (q >> 1) | ((q & 32'd1) << (w - 1));
      MODE_ASR:  return (q >> 1) | (msb << (w - 1));
      MODE_CLR:  return 32'd0;
      default:   return q;
    endcase
  endfunction

  task automatic model_step(input int k);
    logic [31:0] d;
    d = (k == 0) ? {31'd0, d1} : (k == 1) ? {24'd0, d8} : {19'd0, d13};
    if (!rst_n) begin
      mq[k] = rv[k];
      mcnt[k] = 0;
      mdone[k] = 1'b0;
    end else if (en) begin
      mq[k] = model_next(ws[k], mq[k], mode, d, sil, sir);
      if (mode == MODE_LOAD || mode == MODE_CLR) mcnt[k] = 0;
      else if (mode != MODE_HOLD && mcnt[k] < ws[k]) mcnt[k] = mcnt[k] + 1;
      mdone[k] = (mcnt[k] == ws[k]);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] eq, input int ec, input logic ed);
    chk({tag, " Q"}, {24'd0, q8}, {24'd0, eq});
    chk({tag, " Qb"}, {24'd0, qb8}, {24'd0, ~eq});
    chk({tag, " Cnt"}, {28'd0, cnt8}, ec);
    chk({tag, " Done"}, {31'd0, done8}, {31'd0, ed});
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] d);
    mode = m;
    d8 = d;
    d1 = d[0];
    d13 = {5'd0, d};
    tick();
  endtask

  task automatic chk_all(input int k);
    logic [31:0] oq, oqb, mask;
    int oc;
    logic od;
    mask = (32'd1 << ws[k]) - 32'd1;
    case (k)
      0:       begin oq = {31'd0, q1};  oqb = {31'd0, qb1};  oc = int'(cnt1);  od = done1;  end
      1:       begin oq = {24'd0, q8};  oqb = {24'd0, qb8};  oc = int'(cnt8);  od = done8;  end
      default: begin oq = {19'd0, q13}; oqb = {19'd0, qb13}; oc = int'(cnt13); od = done13; end
    endcase
    chk($sformatf("rnd W%0d Q", ws[k]), oq, mq[k]);
    chk($sformatf("rnd W%0d Qb", ws[k]), oqb, ~oq & mask);
    chk($sformatf("rnd W%0d Cnt", ws[k]), oc, mcnt[k]);
    chk($sformatf("rnd W%0d Done", ws[k]), {31'd0, od}, {31'd0, mdone[k]});
    chk($sformatf("rnd W%0d CntLeW", ws[k]), {31'd0, oc <= ws[k]}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_q;
    logic [7:0] ser;
    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; sil = 1'b0; sir = 1'b0;
    d1 = '0; d8 = '0; d13 = '0;
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mcnt[k] = 0; mdone[k] = 1'b0; end

    // 1: reset for two edges
    tick(); tick();
    chk8("reset", 8'hA5, 0, 1'b0);
    chk("reset SoL", {31'd0, sol8}, 32'd1);
    chk("reset SoR", {31'd0, sor8}, 32'd1);

    // 2: LOAD 81 then 8x SHL with SiL=0
    rst_n = 1'b1; en = 1'b1; sil = 1'b0;
    op(MODE_LOAD, 8'h81);
    chk8("load81", 8'h81, 0, 1'b0);
    chk("load81 SoL", {31'd0, sol8}, 32'd1);
    exp_q = 8'h81;
    for (int i = 1; i <= 8; i++) begin
      op(MODE_SHL, 8'h00);
      exp_q = exp_q << 1;
      chk8($sformatf("shl%0d", i), exp_q, i, i == 8);
      chk($sformatf("shl%0d SoL", i), {31'd0, sol8}, {31'd0, exp_q[7]});
    end
    // saturation: a further shift keeps Cnt=8 and Done=1
    sil = 1'b1;
    op(MODE_SHL, 8'h00);
    chk8("shl sat", 8'h01, 8, 1'b1);
    op(MODE_HOLD, 8'hFF);
    chk8("hold", 8'h01, 8, 1'b1);
    op(MODE_CLR, 8'hFF);
    chk8("clr", 8'h00, 0, 1'b0);

    // 3: rotates
    op(MODE_LOAD, 8'h96);
    for (int i = 0; i < 3; i++) op(MODE_ROR, 8'h00);
    chk8("ror3", 8'hD2, 3, 1'b0);
    for (int i = 0; i < 3; i++) op(MODE_ROL, 8'h00);
    chk8("rol3", 8'h96, 6, 1'b0);

    // 4: arithmetic shift then logical shift right
    op(MODE_LOAD, 8'h80);
    op(MODE_ASR, 8'h00);
    op(MODE_ASR, 8'h00);
    chk8("asr2", 8'hE0, 2, 1'b0);
    sir = 1'b0;
    op(MODE_SHR, 8'h00);
    chk8("shr", 8'h70, 3, 1'b0);
    chk("shr SoR", {31'd0, sor8}, 32'd0);

    // 5: enable low holds everything; reset still wins
    en = 1'b0;
    for (int i = 0; i < 5; i++) op(MODE_LOAD, 8'hFF);
    chk8("en0", 8'h70, 3, 1'b0);
    rst_n = 1'b0;
    op(MODE_LOAD, 8'hFF);
    chk8("en0 rst", 8'hA5, 0, 1'b0);

    // 6: deserialise 8'hC3 MSB first, then abort with reset at shift 5
    rst_n = 1'b1; en = 1'b1;
    op(MODE_LOAD, 8'h00);
    ser = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      sil = ser[i];
      op(MODE_SHL, 8'h00);
    end
    chk8("deser", 8'hC3, 8, 1'b1);
    op(MODE_LOAD, 8'h00);
    chk8("load clears done", 8'h00, 0, 1'b0);
    for (int i = 7; i >= 4; i--) begin
      sil = ser[i];
      op(MODE_SHL, 8'h00);
    end
    chk8("deser4", 8'h0C, 4, 1'b0);
    rst_n = 1'b0;
    sil = ser[3];
    op(MODE_SHL, 8'h00);
    chk8("deser abort", 8'hA5, 0, 1'b0);

    // Random: all three widths against the model
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) chk_all(k);
    for (int n = 0; n < 10000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 3'($urandom_range(0, 7));
      if (!en && $urandom_range(0, 3) == 0) mode = 3'bxxx;
      d1    = 1'($urandom);
      d8    = 8'($urandom);
      d13   = 13'($urandom);
      sil   = 1'($urandom);
      sir   = 1'($urandom);
      tick();
      for (int k = 0; k < 3; k++) chk_all(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
